// File: rtl/seq_divider_unit.sv
// Multi-cycle restoring divider for RV32IM DIV/DIVU/REM/REMU.
// Handshakes: a request transfers on a rising edge where in_valid & in_ready & !flush;
// a result transfers on a rising edge where out_valid & out_ready. in_ready is high
// only in IDLE, out_valid only in DONE, and result/tag_out hold while out_valid is
// high and out_ready is low.
module seq_divider_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;          // partial remainder
    logic [WIDTH-1:0]   q_q, q_d;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   m_q, m_d;          // divisor magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rem_sel_q, rem_sel_d;
    logic               sign_q_q, sign_q_d;
    logic               sign_r_q, sign_r_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic               accept;
    logic               signed_op;
    logic               dvd_neg, dsr_neg;
    logic [WIDTH-1:0]   dvd_mag, dsr_mag;
    logic               div_zero, overflow;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;
    assign dbg_state = state_q;

    // Operand decode, one restoring step, sign fix-up, and next-state selection.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        accept    = in_valid & in_ready & ~flush;
        signed_op = ~op[0];
        dvd_neg   = signed_op & dividend[WIDTH-1];
        dsr_neg   = signed_op & divisor[WIDTH-1];
        // Negating the most-negative value yields the same pattern, which read
        // unsigned is exactly its magnitude.
        dvd_mag   = dvd_neg ? -dividend : dividend;
        dsr_mag   = dsr_neg ? -divisor : divisor;
        div_zero  = (divisor == '0);
        overflow  = signed_op & (dividend == MOST_NEG) & (divisor == '1);

        // The partial remainder keeps its top bit in the shift, so a divisor
        // with its MSB set still compares correctly.
        shifted   = {a_q, q_q[WIDTH-1]};
        trial     = shifted - {1'b0, m_q};
        quo_fix   = sign_q_q ? -q_q : q_q;
        rem_fix   = sign_r_q ? -a_q : a_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d     = tag_in;
                    rem_sel_d = op[1];
                    if (div_zero) begin
                        result_d  = op[1] ? dividend : '1;
                        tag_out_d = tag_in;
                        state_d   = DONE;
                    end else if (overflow) begin
                        result_d  = op[1] ? '0 : dividend;
                        tag_out_d = tag_in;
                        state_d   = DONE;
                    end else begin
                        a_d      = '0;
                        q_d      = dvd_mag;
                        m_d      = dsr_mag;
                        cnt_d    = CNT_LOAD;
                        sign_q_d = dvd_neg ^ dsr_neg;
                        sign_r_d = dvd_neg;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    a_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (!flush) begin
                    result_d  = rem_sel_q ? rem_fix : quo_fix;
                    tag_out_d = tag_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            sign_q_q  <= sign_q_d;
            sign_r_q  <= sign_r_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

endmodule
